// File: rtl/piso_shift_ctrl.sv
// Parallel-in/serial-out shifter: valid/ready load, MSB/LSB-first order, bit counter, done pulse.
// Define PISO_PARITY_EN to append a parity bit (PAR state) after the data bits.
module piso_shift_ctrl #(
   parameter int WIDTH      = 8,
   parameter bit LSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b1,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             shen,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sreg
);
   localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t        state, state_nxt;
   logic [CW-1:0] bit_cnt;
   logic          last_data, final_bit, accept, do_shift;

   assign last_data = (state == SHIFT) && (bit_cnt == CW'(WIDTH - 1));

`ifdef PISO_PARITY_EN
   logic par_q;
   assign final_bit = (state == PAR);
`else
   assign final_bit = last_data;
`endif

   // Accepting on the final consuming edge keeps back-to-back words gapless
   assign in_ready = (state == IDLE) || (final_bit && shen);
   assign accept   = in_valid && in_ready;
   assign do_shift = (state == SHIFT) && shen && !final_bit;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt = state;
      ser_out   = IDLE_LEVEL;
      ser_valid = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = SHIFT;
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
            if (shen && last_data) begin
`ifdef PISO_PARITY_EN
               state_nxt = PAR;
`else
               state_nxt = accept ? SHIFT : IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PAR: begin
            ser_valid = 1'b1;
            ser_out   = par_q;
            if (shen) state_nxt = accept ? SHIFT : IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sreg    <= '0;
         bit_cnt <= '0;
         done    <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= final_bit && shen;
         if (accept) begin
            sreg    <= data_in;
            bit_cnt <= '0;
         end else if (do_shift) begin
            sreg <= LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
            // Counter saturates on the last data bit; PAR follows it in parity builds
            if (!last_data) bit_cnt <= bit_cnt + CW'(1);
         end
      end
   end

`ifdef PISO_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= 1'b0;
      end else if (accept) begin
         par_q <= (^data_in) ^ ODD_PARITY;
      end
   end
`endif

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Bench for piso_shift_ctrl: MSB-first and LSB-first instances share stimulus; scoreboard of
// expected serial bits plus a table of words with hand-derived serial streams.
module tb_piso_shift_ctrl;
`ifdef PISO_PARITY_EN
   localparam int WB = 9;
`else
   localparam int WB = 8;
`endif

   logic       clk = 1'b0;
   logic       rst, in_valid, shen;
   logic [7:0] data_in;
   logic       m_rdy, m_so, m_sv, m_busy, m_done;
   logic [7:0] m_sreg;
   logic       l_rdy, l_so, l_sv, l_busy, l_done;
   logic [7:0] l_sreg;

   always #5 clk = ~clk;

   piso_shift_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .ODD_PARITY(1'b0)) u_msb (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(m_rdy),
      .shen(shen), .ser_out(m_so), .ser_valid(m_sv), .busy(m_busy), .done(m_done), .sreg(m_sreg));

   piso_shift_ctrl #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .ODD_PARITY(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(l_rdy),
      .shen(shen), .ser_out(l_so), .ser_valid(l_sv), .busy(l_busy), .done(l_done), .sreg(l_sreg));

   typedef struct packed {
      logic bm;
      logic bl;
      logic last;
   } sb_t;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] pat;
      logic [7:0]  exp_msb;
      logic [7:0]  exp_lsb;
      logic        exp_par;
   } vec_t;

   sb_t         q[$];
   int          done_q[$];
   int          n_checks = 0, n_errors = 0;
   int          cyc = 0, ndone = 0, npulse = 0;
   logic        done_m = 1'b0, acc_evt = 1'b0;
   logic [7:0]  sreg_m = '0, sreg_l = '0;
   logic [31:0] col_m, col_l;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic clear_obs();
      col_m = '0; col_l = '0; npulse = 0; ndone = 0;
      done_q.delete();
   endtask

   // Compare both DUTs against the model at mid-cycle, then advance the model past the edge.
   task automatic cycle();
      logic idle_m, rdy_m, dn;
      @(negedge clk);
      idle_m = (q.size() == 0);
      rdy_m  = idle_m || (shen && q.size() == 1);
      chk("busy_msb", m_busy, !idle_m);
      chk("busy_lsb", l_busy, !idle_m);
      chk("ser_valid_msb", m_sv, !idle_m);
      chk("ser_valid_lsb", l_sv, !idle_m);
      chk("in_ready_msb", m_rdy, rdy_m);
      chk("in_ready_lsb", l_rdy, rdy_m);
      chk("done_msb", m_done, done_m);
      chk("done_lsb", l_done, done_m);
      chk("ser_out_msb", m_so, idle_m ? 1'b1 : q[0].bm);
      chk("ser_out_lsb", l_so, idle_m ? 1'b1 : q[0].bl);
      chk("sreg_msb", m_sreg, sreg_m);
      chk("sreg_lsb", l_sreg, sreg_l);
      if (shen && m_busy) begin
         col_m = {col_m[30:0], m_so};
         col_l = {col_l[30:0], l_so};
         npulse++;
      end
      if (m_done) begin
         ndone++;
         done_q.push_back(cyc);
      end
      acc_evt = 1'b0;
      if (rst) begin
         q.delete();
         done_m = 1'b0;
         sreg_m = '0;
         sreg_l = '0;
      end else begin
         dn = 1'b0;
         if (!idle_m && shen) begin
            dn = q[0].last;
            if (!q[0].last) begin
               sreg_m = sreg_m << 1;
               sreg_l = sreg_l >> 1;
            end
            void'(q.pop_front());
         end
         if (in_valid && rdy_m) begin
            acc_evt = 1'b1;
            sreg_m  = data_in;
            sreg_l  = data_in;
            for (int i = 0; i < 8; i++)
               q.push_back('{bm: data_in[7-i], bl: data_in[i], last: (i == 7) && (WB == 8)});
`ifdef PISO_PARITY_EN
            q.push_back('{bm: ^data_in, bl: ^data_in, last: 1'b1});
`endif
         end
         done_m = dn;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   vec_t tab[6];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] em, el;
      tab[0] = '{data: 8'h55, pat: 16'hFFFF, exp_msb: 8'h55, exp_lsb: 8'hAA, exp_par: 1'b0};
      tab[1] = '{data: 8'h01, pat: 16'hFFFF, exp_msb: 8'h01, exp_lsb: 8'h80, exp_par: 1'b1};
      tab[2] = '{data: 8'hC3, pat: 16'h9999, exp_msb: 8'hC3, exp_lsb: 8'hC3, exp_par: 1'b0};
      tab[3] = '{data: 8'h07, pat: 16'hFFFF, exp_msb: 8'h07, exp_lsb: 8'hE0, exp_par: 1'b1};
      tab[4] = '{data: 8'h03, pat: 16'hFFFF, exp_msb: 8'h03, exp_lsb: 8'hC0, exp_par: 1'b0};
      tab[5] = '{data: 8'hA5, pat: 16'h5555, exp_msb: 8'hA5, exp_lsb: 8'hA5, exp_par: 1'b0};

      rst = 1'b1; in_valid = 1'b0; shen = 1'b0; data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cycle();

      // Single words with varied shen gating
      for (int v = 0; v < 6; v++) begin
         data_in = tab[v].data; in_valid = 1'b1; shen = 1'b1;
         cycle();
         in_valid = 1'b0; data_in = 8'($urandom);
         clear_obs();
         for (int c = 0; c < 64 && ndone == 0; c++) begin
            shen = tab[v].pat[c % 16];
            cycle();
         end
`ifdef PISO_PARITY_EN
         em = {23'd0, tab[v].exp_msb, tab[v].exp_par};
         el = {23'd0, tab[v].exp_lsb, tab[v].exp_par};
`else
         em = {24'd0, tab[v].exp_msb};
         el = {24'd0, tab[v].exp_lsb};
`endif
         chk("vec_done_count", ndone, 1);
         chk("vec_shen_pulses", npulse, WB);
         chk("vec_bits_msb", col_m, em);
         chk("vec_bits_lsb", col_l, el);
         shen = 1'b1;
         cycle();
      end

      // Back-to-back words with in_valid held
      clear_obs();
      data_in = 8'hA5; in_valid = 1'b1; shen = 1'b1;
      cycle();
      data_in = 8'h3C;
      for (int c = 0; c < 40; c++) begin
         cycle();
         if (acc_evt) break;
      end
      in_valid = 1'b0;
      for (int c = 0; c < 40 && q.size() > 0; c++) cycle();
      cycle();
`ifdef PISO_PARITY_EN
      em = {14'd0, 8'hA5, 1'b0, 8'h3C, 1'b0};
`else
      em = {16'd0, 16'hA53C};
`endif
      chk("b2b_bits_msb", col_m, em);
      chk("b2b_bits_lsb", col_l, em);
      chk("b2b_done_count", done_q.size(), 2);
      if (done_q.size() == 2) chk("b2b_done_gap", done_q[1] - done_q[0], WB);

      // Reset mid-word, with a load request that reset must override
      clear_obs();
      data_in = 8'hFF; in_valid = 1'b1; shen = 1'b0;
      cycle();
      in_valid = 1'b0; shen = 1'b1;
      repeat (3) cycle();
      rst = 1'b1; in_valid = 1'b1; data_in = 8'h5A;
      cycle();
      rst = 1'b0; in_valid = 1'b0; shen = 1'b0;
      cycle();
      chk("rst_busy", m_busy, 1'b0);
      chk("rst_sreg", m_sreg, 8'h00);
      chk("rst_ser_out", m_so, 1'b1);
      chk("rst_no_done", ndone, 0);
      clear_obs();
      data_in = 8'h5A; in_valid = 1'b1; shen = 1'b1;
      cycle();
      in_valid = 1'b0;
      for (int c = 0; c < 40 && ndone == 0; c++) cycle();
`ifdef PISO_PARITY_EN
      em = {23'd0, 8'h5A, 1'b0};
`else
      em = {24'd0, 8'h5A};
`endif
      chk("post_rst_bits", col_m, em);
      chk("post_rst_done", ndone, 1);
      repeat (2) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
